// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle RV32I control path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_ILLEGAL
  } state_t;

  // Instruction class presented to the ALU operation decoder
  typedef enum logic [1:0] {
    CLS_MEM,
    CLS_BRANCH,
    CLS_R,
    CLS_I
  } alu_cls_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format follows the opcode alone, independent of FSM state
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    logic [1:0] sel;
    sel = IMM_I;
    case (op)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_dec.sv
// ALU operation decoder: instruction class + funct3/funct7[5] -> ALUControl.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: i_cls (class), i_funct3, i_funct7b5, o_alu_ctrl (4-bit ALU op).
module alu_op_dec
  import multicycle_pkg::*;
(
  input  alu_cls_t   i_cls,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output logic [3:0] o_alu_ctrl
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    case (i_cls)
      CLS_MEM:    o_alu_ctrl = ALU_ADD;
      CLS_BRANCH: o_alu_ctrl = ALU_SUB;
      default: begin
        case (i_funct3)
          // funct7[5] on an I-type add is an immediate bit, so only R-type subtracts
          3'b000:  o_alu_ctrl = (i_cls == CLS_R && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_ctrl = ALU_SLL;
          3'b010:  o_alu_ctrl = ALU_SLT;
          3'b011:  o_alu_ctrl = ALU_SLTU;
          3'b100:  o_alu_ctrl = ALU_XOR;
          3'b101:  o_alu_ctrl = i_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_ctrl = ALU_OR;
          default: o_alu_ctrl = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core (shared memory, single ALU).
// Latency: lw 5, sw/R/I/jal 4, branch 3 cycles, plus one per memory wait cycle.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready is high.
// Ports: clk/rst_n; Instr, Zero, mem_ready in; datapath strobes, mux selects,
//   ALUControl, ImmSrc and illegal out (combinational from state and inputs).
// Option: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN makes illegal instructions trap
//   (sticky illegal flag until reset); otherwise they execute as a NOP.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH,
  parameter bit     BNE_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  ResultSrc,
  output logic        RegWrite,
  output logic        illegal
);

  state_t     r_state;
  state_t     w_dec_next;
  alu_cls_t   w_cls;
  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_f7b5;
  logic       w_br_legal;
  logic [3:0] w_alu_dec;
  logic       w_unused;

  assign w_op     = Instr[6:0];
  assign w_f3     = Instr[14:12];
  assign w_f7b5   = Instr[30];
  assign w_unused = ^{Instr[31], Instr[29:15], Instr[11:7]};

  // Only beq (and bne when enabled) are decoded as branches
  assign w_br_legal = (w_f3 == 3'b000) || (BNE_EN && (w_f3 == 3'b001));

  always_comb begin
    w_dec_next = S_ILLEGAL;
    case (w_op)
      OP_LOAD, OP_STORE: w_dec_next = S_MEMADR;
      OP_RTYPE:          w_dec_next = S_EXECR;
      OP_ITYPE:          w_dec_next = S_EXECI;
      OP_BRANCH:         w_dec_next = w_br_legal ? S_BRANCH : S_ILLEGAL;
      OP_JAL:            w_dec_next = S_JAL;
      default:           w_dec_next = S_ILLEGAL;
    endcase
  end

  // States outside the ALU-using ones fall back to CLS_MEM, which yields ADD
  always_comb begin
    w_cls = CLS_MEM;
    case (r_state)
      S_EXECR:  w_cls = CLS_R;
      S_EXECI:  w_cls = CLS_I;
      S_BRANCH: w_cls = CLS_BRANCH;
      default:  w_cls = CLS_MEM;
    endcase
  end

  alu_op_dec u_alu_op_dec (
    .i_cls      (w_cls),
    .i_funct3   (w_f3),
    .i_funct7b5 (w_f7b5),
    .o_alu_ctrl (w_alu_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_STATE;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE:   r_state <= w_dec_next;
        S_MEMADR:   r_state <= (w_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_EXECR, S_EXECI, S_JAL: r_state <= S_ALUWB;
        S_MEMWB, S_ALUWB, S_BRANCH: r_state <= S_FETCH;
        S_ILLEGAL: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          r_state <= S_ILLEGAL;
`else
          r_state <= S_FETCH;
`endif
        end
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = ADR_PC;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_B;
    ALUControl = w_alu_dec;
    ImmSrc     = imm_src(w_op);
    ResultSrc  = RES_ALUOUT;
    RegWrite   = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into PC as the fetch completes
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_4;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR, S_EXECI: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = ADR_RESULT;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = ADR_RESULT;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_A;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_A;
        PCWrite = (w_f3 == 3'b000) ? Zero : ~Zero;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_4;
        PCWrite = 1'b1;
      end
      S_ILLEGAL: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`else
        illegal = 1'b0;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: instruction-level reference model,
// directed instructions with pinned latencies, then randomized instructions,
// memory wait states and Zero values.
module tb_multicycle_ctrl;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011;
  localparam logic [6:0] T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
  localparam logic [3:0] A_SLT = 4'd5, A_SLTU = 4'd6, A_SLL = 4'd7, A_SRL = 4'd8, A_SRA = 4'd9;

  // Step kinds of an instruction's life, from the instruction's point of view
  localparam int K_FETCH = 0, K_DEC = 1, K_ADDR = 2, K_RD = 3, K_RDWB = 4, K_WR = 5;
  localparam int K_EXR = 6, K_EXI = 7, K_WB = 8, K_BR = 9, K_JAL = 10, K_NOP = 11, K_TRAP = 12;

  typedef struct packed {
    logic       mreq;
    logic       mw;
    logic       irw;
    logic       pcw;
    logic       adr;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [3:0] alu;
    logic [1:0] imm;
    logic [1:0] res;
    logic       rw;
    logic       ill;
  } out_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] Instr;
  logic        Zero;
  logic        mem_ready;
  logic        mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite, illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
  logic [3:0]  ALUControl;

  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   chk_en = 0;
  int   cyc    = 0;
  int   cur_kind = 0;
  out_t want;
  out_t got;
  out_t obs [64];

  multicycle_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Instr      (Instr),
    .Zero       (Zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .ResultSrc  (ResultSrc),
    .RegWrite   (RegWrite),
    .illegal    (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit is_illegal_instr(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    if (op == T_LOAD || op == T_STORE || op == T_R || op == T_I || op == T_JAL) return 1'b0;
    if (op == T_BR && ins[14:13] == 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit is_mem_kind(input int k);
    return (k == K_FETCH || k == K_RD || k == K_WR);
  endfunction

  task automatic build_steps(input logic [31:0] ins, output int q[$]);
    logic [6:0] op;
    op = ins[6:0];
    q = {};
    q.push_back(K_FETCH);
    q.push_back(K_DEC);
    if (is_illegal_instr(ins)) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      repeat (3) q.push_back(K_TRAP);
`else
      q.push_back(K_NOP);
`endif
    end else if (op == T_LOAD) begin
      q.push_back(K_ADDR); q.push_back(K_RD); q.push_back(K_RDWB);
    end else if (op == T_STORE) begin
      q.push_back(K_ADDR); q.push_back(K_WR);
    end else if (op == T_R) begin
      q.push_back(K_EXR); q.push_back(K_WB);
    end else if (op == T_I) begin
      q.push_back(K_EXI); q.push_back(K_WB);
    end else if (op == T_BR) begin
      q.push_back(K_BR);
    end else begin
      q.push_back(K_JAL); q.push_back(K_WB);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic f7, input bit is_r);
    logic [3:0] tbl [8];
    tbl = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    if (f3 == 3'd0 && is_r && f7) return A_SUB;
    if (f3 == 3'd5 && f7) return A_SRA;
    return tbl[f3];
  endfunction

  function automatic out_t model(input int k, input logic [31:0] ins, input logic z, input logic mr);
    out_t e;
    logic [6:0] op;
    op = ins[6:0];
    e = '0;
    e.imm = (op == T_STORE) ? 2'b01 : (op == T_BR) ? 2'b10 : (op == T_JAL) ? 2'b11 : 2'b00;
    case (k)
      K_FETCH: begin e.mreq = 1; e.srcb = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
      K_DEC:   begin e.srca = 2'b01; e.srcb = 2'b01; end
      K_ADDR:  begin e.srca = 2'b10; e.srcb = 2'b01; end
      K_RD:    begin e.mreq = 1; e.adr = 1; end
      K_RDWB:  begin e.res = 2'b01; e.rw = 1; end
      K_WR:    begin e.mreq = 1; e.mw = 1; e.adr = 1; end
      K_EXR:   begin e.srca = 2'b10; e.alu = ref_alu(ins[14:12], ins[30], 1'b1); end
      K_EXI:   begin e.srca = 2'b10; e.srcb = 2'b01; e.alu = ref_alu(ins[14:12], ins[30], 1'b0); end
      K_WB:    e.rw = 1;
      K_BR:    begin e.srca = 2'b10; e.alu = A_SUB; e.pcw = ins[12] ? ~z : z; end
      K_JAL:   begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1; end
      K_TRAP:  e.ill = 1;
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input int g, input int w);
    n_cmp++;
    if (g != w) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", nm, g, w);
    end
  endtask

  // Sole per-cycle compare against the model; also logs what the DUT showed
  always @(negedge clk) begin
    if (chk_en) begin
      got = '{mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
              ALUControl, ImmSrc, ResultSrc, RegWrite, illegal};
      if (cyc < 64) obs[cyc] = got;
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL cycle_outputs instr=%08h step=%0d cyc=%0d got=%05h want=%05h",
                 Instr, cur_kind, cyc, got, want);
      end
    end
  end

  // fw/dw: wait cycles per fetch / data access (-1 = random); zm: 0/1 fixed Zero, 2 random
  task automatic run_instr(input logic [31:0] ins, input int fw, input int dw, input int zm,
                           input int stop_at, output int cycles);
    int q[$];
    int idx, wc, c, k;
    logic mr;
    build_steps(ins, q);
    idx = 0; wc = 0; c = 0;
    Instr = ins;
    while (idx < q.size()) begin
      k = q[idx];
      if (k == K_FETCH)
        mr = (fw < 0) ? ($urandom_range(99) >= 30) : (wc >= fw);
      else if (k == K_RD || k == K_WR)
        mr = (dw < 0) ? ($urandom_range(99) >= 30) : (wc >= dw);
      else
        mr = 1'($urandom_range(1));
      mem_ready = mr;
      Zero      = (zm > 1) ? 1'($urandom_range(1)) : (zm == 1);
      cyc       = c;
      cur_kind  = k;
      want      = model(k, ins, Zero, mr);
      chk_en    = 1;
      @(posedge clk); #1;
      c++;
      if (is_mem_kind(k) && !mr) wc++;
      else begin idx++; wc = 0; end
      if (stop_at >= 0 && c >= stop_at) break;
      if (c > 300) begin
        chk("instr_timeout", c, 300);
        break;
      end
    end
    chk_en = 0;
    cycles = c;
  endtask

  // Reset asserted between clock edges: outputs must show FETCH immediately
  task automatic do_reset();
    chk_en = 0;
    mem_ready = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_mem_req", mem_req, 1);
    chk("rst_alusrcb", ALUSrcB, 2);
    chk("rst_resultsrc", ResultSrc, 2);
    chk("rst_adrsrc", AdrSrc, 0);
    chk("rst_illegal", illegal, 0);
    @(posedge clk); #1 rst_n = 1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0:       return {r[31:15], 3'b010, r[11:7], T_LOAD};
      1:       return {r[31:15], 3'b010, r[11:7], T_STORE};
      2, 3:    return {r[31:7], T_R};
      4, 5:    return {r[31:7], T_I};
      6:       return {r[31:15], 2'b00, r[12], r[11:7], T_BR};
      7:       return {r[31:7], T_JAL};
      8:       return {r[31:7], 7'b0110111};
      default: return {r[31:7], 7'b0000000};
    endcase
  endfunction

  initial begin
    int n, rw_cnt, mw_cnt, mr_cnt;
    logic [31:0] ins;
    rst_n = 1; Instr = 0; Zero = 0; mem_ready = 0;
    @(posedge clk); #1;
    do_reset();

    // add x3,x1,x2
    run_instr(32'h002081B3, 0, 0, 0, -1, n);
    chk("add_cycles", n, 4);
    chk("add_aluctrl_execr", obs[2].alu, 0);
    rw_cnt = 0; for (int i = 0; i < n; i++) rw_cnt += obs[i].rw;
    chk("add_regwrite_count", rw_cnt, 1);
    chk("add_regwrite_cyc4", obs[3].rw, 1);

    // lw x5,8(x1) with two wait cycles in MEMREAD
    run_instr(32'h0080A283, 0, 2, 0, -1, n);
    chk("lw_cycles", n, 7);
    mr_cnt = 0; for (int i = 0; i < n; i++) mr_cnt += (obs[i].mreq && obs[i].adr);
    chk("lw_memread_held", mr_cnt, 3);
    chk("lw_wb_regwrite", obs[6].rw, 1);
    chk("lw_wb_resultsrc", obs[6].res, 1);

    // sw x5,12(x1)
    run_instr(32'h0050A623, 0, 0, 0, -1, n);
    chk("sw_cycles", n, 4);
    chk("sw_immsrc_memadr", obs[2].imm, 1);
    mw_cnt = 0; rw_cnt = 0;
    for (int i = 0; i < n; i++) begin mw_cnt += obs[i].mw; rw_cnt += obs[i].rw; end
    chk("sw_memwrite_count", mw_cnt, 1);
    chk("sw_memwrite_at_memwrite", obs[3].mw, 1);
    chk("sw_regwrite_count", rw_cnt, 0);

    // beq x1,x2,+16, taken then not taken
    run_instr(32'h00208863, 0, 0, 1, -1, n);
    chk("beq_cycles", n, 3);
    chk("beq_taken_pcwrite", obs[2].pcw, 1);
    chk("beq_sub", obs[2].alu, 1);
    chk("beq_immsrc_decode", obs[1].imm, 2);
    run_instr(32'h00208863, 0, 0, 0, -1, n);
    chk("beq_not_taken_pcwrite", obs[2].pcw, 0);
    // bne inverts the sense of Zero
    run_instr(32'h00209863, 0, 0, 0, -1, n);
    chk("bne_taken_pcwrite", obs[2].pcw, 1);

    // jal x1,+8
    run_instr(32'h008000EF, 0, 0, 0, -1, n);
    chk("jal_cycles", n, 4);
    chk("jal_immsrc_decode", obs[1].imm, 3);
    chk("jal_pcwrite", obs[2].pcw, 1);
    chk("jal_aluwb_regwrite", obs[3].rw, 1);

    // all-zero instruction word
    run_instr(32'h00000000, 0, 0, 0, -1, n);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    chk("illegal_sticky_a", obs[2].ill, 1);
    chk("illegal_sticky_b", obs[4].ill, 1);
    chk("illegal_still_set", illegal, 1);
    do_reset();
`else
    chk("illegal_nop_cycles", n, 3);
    chk("illegal_flag_low", obs[2].ill, 0);
`endif

    // reset arriving while a load waits in MEMREAD
    run_instr(32'h0080A283, 0, 20, 0, 5, n);
    chk("midread_mem_req", mem_req, 1);
    chk("midread_adrsrc", AdrSrc, 1);
    do_reset();
    run_instr(32'h002081B3, 0, 0, 0, -1, n);
    chk("after_reset_add_cycles", n, 4);

    // randomized instruction stream, waits and Zero
    for (int t = 0; t < 200; t++) begin
      ins = rand_instr();
      run_instr(ins, -1, -1, 2, -1, n);
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
      if (is_illegal_instr(ins)) do_reset();
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
